wb_bus_decoder: RTL

//  Parametrised single-master Wishbone (classic) address decoder for the SoC, scaling to NUM_SLAVES targets.

---
 rtl/wb_bus_decoder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/wb_bus_decoder.sv
// Single-master Wishbone classic address decoder with per-slave windows,
// an unmapped-address error response and a bus-timeout watchdog.
module wb_bus_decoder #(
    parameter int                                      WB_DATA_WIDTH  = 32,
    parameter int                                      WB_ADDR_WIDTH  = 32,
    parameter int                                      WB_SEL_WIDTH   = 4,
    parameter int                                      NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]     SLAVE_BASE     = {32'h0003_0000, 32'h0002_0000,
                                                                         32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]     SLAVE_MASK     = {32'hFFFF_0000, 32'hFFFF_0000,
                                                                         32'hFFFF_0000, 32'hFFFF_0000},
    parameter int                                      TIMEOUT_CYCLES = 255,
    parameter logic [WB_DATA_WIDTH-1:0]                ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [WB_ADDR_WIDTH-1:0]              m_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]              m_dat_i,
    input  logic                                  m_we_i,
    input  logic [WB_SEL_WIDTH-1:0]               m_sel_i,
    input  logic                                  m_stb_i,
    input  logic                                  m_cyc_i,
    output logic                                  m_ack_o,
    output logic                                  m_err_o,
    output logic [WB_DATA_WIDTH-1:0]              m_dat_o,
    output logic [WB_ADDR_WIDTH-1:0]              s_adr_o,
    output logic [WB_DATA_WIDTH-1:0]              s_dat_o,
    output logic                                  s_we_o,
    output logic [WB_SEL_WIDTH-1:0]               s_sel_o,
    output logic [NUM_SLAVES-1:0]                 s_stb_o,
    output logic [NUM_SLAVES-1:0]                 s_cyc_o,
    input  logic [NUM_SLAVES-1:0]                 s_ack_i,
    input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]   s_dat_i,
    output logic                                  err_irq_o,
    output logic [1:0]                            err_cause_o,
    output logic [WB_ADDR_WIDTH-1:0]              err_addr_o
);

    localparam int AW      = WB_ADDR_WIDTH;
    localparam int DW      = WB_DATA_WIDTH;
    localparam int SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

    localparam logic [CNT_W-1:0] TMO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       CAUSE_UNMAP  = 2'b01;
    localparam logic [1:0]       CAUSE_TMO    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    state_t              state_q;
    logic [SEL_W-1:0]    sel_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          err_cause_q;
    logic [AW-1:0]       err_addr_q;

    logic                hit_d;
    logic [SEL_W-1:0]    hit_idx_d;
    logic [NUM_SLAVES-1:0] sel_oh;
    logic                sel_ack;
    logic [DW-1:0]       sel_dat;
    logic                live;
    logic                ack_ok;
    logic                err_st;
    logic                timeout;

    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_we_o  = m_we_i;
    assign s_sel_o = m_sel_i;

    // Scan from the top down so the lowest-index matching window ends up selected.
    always_comb begin
        hit_d     = 1'b0;
        hit_idx_d = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((m_adr_i & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
                hit_d     = 1'b1;
                hit_idx_d = SEL_W'(k);
            end
        end
    end

    always_comb begin
        sel_oh  = '0;
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_oh[k] = 1'b1;
                sel_ack   = s_ack_i[k];
                sel_dat   = s_dat_i[k*DW +: DW];
            end
        end
    end

    // Slave handshakes are gated by m_cyc_i so a master abort releases the slave immediately.
    assign live    = (state_q == ST_ACTIVE) && m_cyc_i;
    assign ack_ok  = live && sel_ack;
    assign err_st  = (state_q == ST_ERR);
    assign timeout = (cnt_q == TMO_LAST);

    assign s_cyc_o     = live ? sel_oh : '0;
    assign s_stb_o     = live ? sel_oh : '0;
    assign m_ack_o     = ack_ok || err_st;
    assign m_err_o     = err_st;
    assign err_irq_o   = err_st;
    assign m_dat_o     = err_st ? ERR_DATA : (ack_ok ? sel_dat : '0);
    assign err_cause_o = err_cause_q;
    assign err_addr_o  = err_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            err_cause_q <= '0;
            err_addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        if (hit_d) begin
                            sel_q   <= hit_idx_d;
                            cnt_q   <= '0;
                            state_q <= ST_ACTIVE;
                        end else begin
                            err_addr_q  <= m_adr_i;
                            err_cause_q <= CAUSE_UNMAP;
                            state_q     <= ST_ERR;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!m_cyc_i) begin
                        state_q <= ST_IDLE;
                    end else if (sel_ack) begin
                        state_q <= ST_IDLE;
                    end else if (timeout) begin
                        err_addr_q  <= m_adr_i;
                        err_cause_q <= CAUSE_TMO;
                        state_q     <= ST_ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ERR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
